nibble_loop_sched: RTL and testbench



---
 rtl/nibble_loop_sched.sv | 159 +++++++++++++++
 tb/tb_nibble_loop_sched.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_loop_sched.sv
// Two-client round-robin scheduler for a shared nibble-serial ALU loop unit.
// Latches the winning job, sequences the loop unit through preload and count, returns result.
module nibble_loop_sched #(
   parameter int unsigned TIMEOUT_CYCLES = 20
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [3:0]  req0_cmd,
   input  logic [2:0]  req0_nibbles,
   input  logic        req0_neg,
   input  logic [31:0] req0_w1,
   input  logic [31:0] req0_w2,
   input  logic [31:0] req0_preinit,

   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [3:0]  req1_cmd,
   input  logic [2:0]  req1_nibbles,
   input  logic        req1_neg,
   input  logic [31:0] req1_w1,
   input  logic [31:0] req1_w2,
   input  logic [31:0] req1_preinit,

   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_timeout,

   output logic        loop_perm_to_count,
   output logic [2:0]  loop_nibbles_number,
   output logic [7:0]  loop_ctrl,
   output logic        loop_word2_is_negative,
   output logic [31:0] loop_word1,
   output logic [31:0] loop_word2,
   output logic [31:0] loop_preinit,
   input  logic        loop_busy,
   input  logic [31:0] loop_result
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {StIdle, StArm, StRun, StResp} state_t;

   state_t         state_q;
   logic           last_grant_q;
   logic           owner_q;
   logic [3:0]     cmd_q;
   logic [2:0]     nib_q;
   logic           neg_q;
   logic [31:0]    w1_q;
   logic [31:0]    w2_q;
   logic [31:0]    pre_q;
   logic [CntW-1:0] tcnt_q;
   logic           perm_q;
   logic           rsp0_valid_q;
   logic           rsp1_valid_q;
   logic [31:0]    result_q;
   logic           timeout_q;

   logic           grant_any;
   logic           grant_sel;
   logic           rsp_hs;

   // On a tie the requester that did not win last time is granted.
   always_comb begin
      grant_any  = (state_q == StIdle) && (req0_valid || req1_valid);
      grant_sel  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
      req0_ready = grant_any && !grant_sel;
      req1_ready = grant_any && grant_sel;
      rsp_hs     = owner_q ? rsp1_ready : rsp0_ready;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         cmd_q        <= '0;
         nib_q        <= '0;
         neg_q        <= 1'b0;
         w1_q         <= '0;
         w2_q         <= '0;
         pre_q        <= '0;
         tcnt_q       <= '0;
         perm_q       <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         result_q     <= '0;
         timeout_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (grant_any) begin
                  owner_q      <= grant_sel;
                  last_grant_q <= grant_sel;
                  cmd_q        <= grant_sel ? req1_cmd     : req0_cmd;
                  nib_q        <= grant_sel ? req1_nibbles : req0_nibbles;
                  neg_q        <= grant_sel ? req1_neg     : req0_neg;
                  w1_q         <= grant_sel ? req1_w1      : req0_w1;
                  w2_q         <= grant_sel ? req1_w2      : req0_w2;
                  pre_q        <= grant_sel ? req1_preinit : req0_preinit;
                  state_q      <= StArm;
               end
            end
            StArm: begin
               tcnt_q  <= '0;
               perm_q  <= 1'b1;
               state_q <= StRun;
            end
            StRun: begin
               tcnt_q <= tcnt_q + CntW'(1);
               // Busy is stale in the first RUN cycle, so completion is only honoured later.
               if ((tcnt_q != '0) && !loop_busy) begin
                  result_q     <= loop_result;
                  timeout_q    <= 1'b0;
                  perm_q       <= 1'b0;
                  rsp0_valid_q <= !owner_q;
                  rsp1_valid_q <= owner_q;
                  state_q      <= StResp;
               end else if (tcnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                  result_q     <= '0;
                  timeout_q    <= 1'b1;
                  perm_q       <= 1'b0;
                  rsp0_valid_q <= !owner_q;
                  rsp1_valid_q <= owner_q;
                  state_q      <= StResp;
               end
            end
            StResp: begin
               if (rsp_hs) begin
                  rsp0_valid_q <= 1'b0;
                  rsp1_valid_q <= 1'b0;
                  state_q      <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign rsp0_valid             = rsp0_valid_q;
   assign rsp1_valid             = rsp1_valid_q;
   assign rsp_result             = result_q;
   assign rsp_timeout            = timeout_q;
   assign loop_perm_to_count     = perm_q;
   assign loop_nibbles_number    = nib_q;
   // {cmd, carry_in, reserved}; carry_in is left at 0 for the loop unit to own.
   assign loop_ctrl              = {cmd_q, 4'b0000};
   assign loop_word2_is_negative = neg_q;
   assign loop_word1             = w1_q;
   assign loop_word2             = w2_q;
   assign loop_preinit           = pre_q;

endmodule

// File: tb/tb_nibble_loop_sched.sv
// Randomized bench for nibble_loop_sched: behavioural loop-unit stub plus a
// job-level reference model that predicts grants, latency, routing and results.
module tb_nibble_loop_sched;

   localparam int unsigned T = 20;
   localparam logic [3:0] CmdAdd = 4'd0, CmdSub = 4'd1, CmdRshft = 4'd2, CmdAnd = 4'd3;

   typedef struct {
      logic [3:0]  cmd;
      logic [2:0]  nib;
      logic        neg;
      logic [31:0] w1, w2, pre, exp_res;
      logic        use_exp;
   } job_t;

   logic        clk, rst;
   logic        req0_valid, req0_ready, req0_neg, req1_valid, req1_ready, req1_neg;
   logic [3:0]  req0_cmd, req1_cmd;
   logic [2:0]  req0_nibbles, req1_nibbles;
   logic [31:0] req0_w1, req0_w2, req0_preinit, req1_w1, req1_w2, req1_preinit;
   logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready, rsp_timeout;
   logic [31:0] rsp_result;
   logic        loop_perm_to_count, loop_word2_is_negative, loop_busy;
   logic [2:0]  loop_nibbles_number;
   logic [7:0]  loop_ctrl;
   logic [31:0] loop_word1, loop_word2, loop_preinit, loop_result;

   nibble_loop_sched #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
      .req0_nibbles(req0_nibbles), .req0_neg(req0_neg), .req0_w1(req0_w1),
      .req0_w2(req0_w2), .req0_preinit(req0_preinit),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
      .req1_nibbles(req1_nibbles), .req1_neg(req1_neg), .req1_w1(req1_w1),
      .req1_w2(req1_w2), .req1_preinit(req1_preinit),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result), .rsp_timeout(rsp_timeout),
      .loop_perm_to_count(loop_perm_to_count), .loop_nibbles_number(loop_nibbles_number),
      .loop_ctrl(loop_ctrl), .loop_word2_is_negative(loop_word2_is_negative),
      .loop_word1(loop_word1), .loop_word2(loop_word2), .loop_preinit(loop_preinit),
      .loop_busy(loop_busy), .loop_result(loop_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_result(input logic [3:0] cmd, input logic [2:0] nib,
                                              input logic neg, input logic [31:0] w1,
                                              input logic [31:0] w2);
      logic [31:0] x;
      int top;
      x   = w2;
      top = 4 * int'(nib) + 3;
      if (neg) for (int i = 0; i < 32; i++) if (i > top) x[i] = x[top];
      case (cmd)
         CmdAdd:   return w1 + x;
         CmdSub:   return w1 - x;
         CmdRshft: return neg ? {x[31], x[31:1]} : (x >> 1);
         default:  return w1 & w2;
      endcase
   endfunction

   // Loop-unit work length in count cycles: one per nibble plus a preinit-selected tail.
   function automatic int run_len(input logic [2:0] nib, input logic [31:0] pre);
      return int'(nib) + 1 + int'(pre[3:0]);
   endfunction

   // Loop-unit stub: busy reads 0 (stale) in its first count cycle, garbage result while busy.
   logic [5:0]  stub_cnt;
   logic        stub_stuck;
   logic        stub_done;
   logic [31:0] stub_res;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      stub_cnt <= '0;
      else if (!loop_perm_to_count) stub_cnt <= '0;
      else if (stub_cnt != 6'd63)   stub_cnt <= stub_cnt + 6'd1;
   end

   always_comb begin
      stub_res  = ref_result(loop_ctrl[7:4], loop_nibbles_number, loop_word2_is_negative,
                             loop_word1, loop_word2);
      stub_done = (stub_cnt != 6'd0) &&
                  (int'(stub_cnt) >= run_len(loop_nibbles_number, loop_preinit));
      loop_busy   = stub_stuck || ((stub_cnt != 6'd0) && !stub_done);
      loop_result = stub_done ? stub_res : ~stub_res;
   end

   // Reference model (job level): 0 idle, 1 waiting for result, 2 responding.
   job_t        q0[$], q1[$];
   job_t        cur0, cur1, m_job;
   int          m_state, m_wait, m_age, m_done;
   logic        m_last, m_owner, m_arm, m_exp_to;
   logic [31:0] m_exp_res;
   logic [1:0]  granted;
   int          hold, prob;

   function automatic job_t mk(input logic [3:0] cmd, input logic [2:0] nib, input logic neg,
                               input logic [31:0] w1, input logic [31:0] w2,
                               input logic [31:0] pre, input logic use_exp,
                               input logic [31:0] exp_res);
      job_t j;
      j.cmd = cmd; j.nib = nib; j.neg = neg; j.w1 = w1; j.w2 = w2; j.pre = pre;
      j.use_exp = use_exp; j.exp_res = exp_res;
      return j;
   endfunction

   task automatic model_reset();
      m_state = 0; m_last = 1'b1; m_owner = 1'b0; m_arm = 1'b0; m_wait = 0; m_age = 0;
      granted = 2'b00;
   endtask

   task automatic step();
      logic [1:0] exp_ready, exp_valid;
      logic       exp_perm, g;
      int         k;
      exp_ready = 2'b00; exp_valid = 2'b00; exp_perm = 1'b0; g = 1'b0;
      if (m_state == 0 && (req0_valid || req1_valid)) begin
         g = (req0_valid && req1_valid) ? !m_last : req1_valid;
         exp_ready[g] = 1'b1;
      end
      if (m_state == 1) exp_perm = !m_arm;
      if (m_state == 2) exp_valid[m_owner] = 1'b1;
      check("req_ready", 128'({req1_ready, req0_ready}), 128'(exp_ready));
      check("loop_perm", 128'(loop_perm_to_count), 128'(exp_perm));
      check("rsp_valid", 128'({rsp1_valid, rsp0_valid}), 128'(exp_valid));
      if (m_state == 1)
         check("loop_ops",
               128'({loop_ctrl, loop_nibbles_number, loop_word2_is_negative,
                     loop_word1, loop_word2, loop_preinit}),
               128'({m_job.cmd, 4'b0000, m_job.nib, m_job.neg, m_job.w1, m_job.w2,
                     m_job.pre}));
      if (m_state == 2) begin
         check("rsp_result", 128'(rsp_result), 128'(m_exp_res));
         check("rsp_timeout", 128'(rsp_timeout), 128'(m_exp_to));
      end
      case (m_state)
         0: if (req0_valid || req1_valid) begin
            m_last = g; m_owner = g; granted[g] = 1'b1;
            m_job  = g ? cur1 : cur0;
            m_exp_to = stub_stuck || (run_len(m_job.nib, m_job.pre) + 1 > int'(T));
            k = m_exp_to ? int'(T) : run_len(m_job.nib, m_job.pre) + 1;
            m_exp_res = m_exp_to ? 32'h0 :
                        (m_job.use_exp ? m_job.exp_res :
                         ref_result(m_job.cmd, m_job.nib, m_job.neg, m_job.w1, m_job.w2));
            m_wait = k + 1; m_arm = 1'b1; m_state = 1;
         end
         1: begin
            m_arm = 1'b0;
            m_wait--;
            if (m_wait == 0) begin m_state = 2; m_age = 0; end
         end
         default: begin
            m_age++;
            if (m_owner ? rsp1_ready : rsp0_ready) begin m_state = 0; m_done++; end
         end
      endcase
   endtask

   task automatic drive();
      logic r0, r1;
      if (granted[0]) begin granted[0] = 1'b0; req0_valid = 1'b0; end
      if (granted[1]) begin granted[1] = 1'b0; req1_valid = 1'b0; end
      if (!req0_valid && q0.size() > 0) begin
         cur0 = q0.pop_front();
         req0_cmd = cur0.cmd; req0_nibbles = cur0.nib; req0_neg = cur0.neg;
         req0_w1 = cur0.w1; req0_w2 = cur0.w2; req0_preinit = cur0.pre; req0_valid = 1'b1;
      end
      if (!req1_valid && q1.size() > 0) begin
         cur1 = q1.pop_front();
         req1_cmd = cur1.cmd; req1_nibbles = cur1.nib; req1_neg = cur1.neg;
         req1_w1 = cur1.w1; req1_w2 = cur1.w2; req1_preinit = cur1.pre; req1_valid = 1'b1;
      end
      r0 = (hold == 0) ? 1'($urandom_range(1)) : 1'b0;
      r1 = (hold == 0) ? 1'($urandom_range(1)) : 1'b0;
      if (m_state == 2) begin
         if (m_owner) r1 = (m_age >= hold) && ($urandom_range(99) < prob);
         else         r0 = (m_age >= hold) && ($urandom_range(99) < prob);
      end
      rsp0_ready = r0;
      rsp1_ready = r1;
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); step();
         @(posedge clk); #1; drive();
      end
   endtask

   task automatic run_until_idle(input int budget);
      int   n;
      logic idle;
      n = 0;
      do begin
         @(negedge clk); step();
         @(posedge clk); #1; drive();
         n++;
         idle = (m_state == 0) && !req0_valid && !req1_valid && q0.size() == 0 &&
                q1.size() == 0;
      end while (!idle && n < budget);
      check("cycle_budget", 128'(idle), 128'(1'b1));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctl"}, 128'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result,
                                  rsp_timeout, loop_perm_to_count, loop_nibbles_number,
                                  loop_ctrl, loop_word2_is_negative}), 128'(0));
      check({tag, "_ops"}, 128'({loop_word1, loop_word2, loop_preinit}), 128'(0));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      q0.delete(); q1.delete();
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
   endtask

   initial begin
      int jobs;
      rst = 1'b1; stub_stuck = 1'b0; hold = 0; prob = 100; m_done = 0;
      req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      req0_cmd = '0; req0_nibbles = '0; req0_neg = 1'b0;
      req0_w1 = '0; req0_w2 = '0; req0_preinit = '0;
      req1_cmd = '0; req1_nibbles = '0; req1_neg = 1'b0;
      req1_w1 = '0; req1_w2 = '0; req1_preinit = '0;
      model_reset();
      #1 check_all_zero("reset_async");
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      check_all_zero("reset_release");

      // ADD on req0 alone, then a sign-extended short ADD on req1
      q0.push_back(mk(CmdAdd, 3'd7, 1'b0, 32'h0EFF_FFFF, 32'h1, 32'hF000_0000, 1'b1,
                      32'h0F00_0000));
      run_until_idle(200);
      q1.push_back(mk(CmdAdd, 3'd1, 1'b1, 32'h0000_FFFF, 32'h0000_00FF, 32'h0, 1'b1,
                      32'h0000_FFFE));
      run_until_idle(200);

      // Both requesters continuously valid straight out of reset
      do_reset();
      for (int i = 0; i < 2; i++) begin
         q0.push_back(mk(CmdSub, 3'($urandom_range(7)), 1'b0, $urandom, $urandom,
                         32'h0000_0000, 1'b0, 32'h0));
         q1.push_back(mk(CmdAnd, 3'($urandom_range(7)), 1'b0, $urandom, $urandom,
                         32'h0000_0002, 1'b0, 32'h0));
      end
      prob = 100;
      run_until_idle(400);

      // Backpressure on rsp0 with req1 waiting
      hold = 10;
      q0.push_back(mk(CmdAdd, 3'd3, 1'b0, $urandom, $urandom, 32'h0, 1'b0, 32'h0));
      q1.push_back(mk(CmdAdd, 3'd5, 1'b1, $urandom, $urandom, 32'h0, 1'b0, 32'h0));
      run_until_idle(400);
      hold = 0;

      // Completion exactly on the timeout cycle, then one cycle too late
      q0.push_back(mk(CmdAdd, 3'd7, 1'b0, 32'h1234_5678, 32'h1111_1111, 32'h0000_000B, 1'b1,
                      32'h2345_6789));
      q1.push_back(mk(CmdAdd, 3'd7, 1'b0, 32'h1234_5678, 32'h1111_1111, 32'h0000_000C, 1'b0,
                      32'h0));
      run_until_idle(400);

      // Loop unit stuck busy
      stub_stuck = 1'b1;
      q1.push_back(mk(CmdAdd, 3'd7, 1'b0, $urandom, $urandom, 32'h0, 1'b0, 32'h0));
      run_until_idle(400);
      stub_stuck = 1'b0;

      // Reset in the middle of RUN, then an RSHFT job
      q0.push_back(mk(CmdAdd, 3'd7, 1'b0, $urandom, $urandom, 32'h0000_000F, 1'b0, 32'h0));
      run_cycles(8);
      check("mid_run_perm", 128'(loop_perm_to_count), 128'(1'b1));
      #2 rst = 1'b1;
      #1 check_all_zero("reset_mid_run");
      req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      q0.delete(); q1.delete();
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      run_cycles(30);
      q0.push_back(mk(CmdRshft, 3'd7, 1'b0, 32'h0, 32'h0600_0000, 32'h0, 1'b1, 32'h0300_0000));
      run_until_idle(200);

      // Random traffic
      m_done = 0;
      prob = 60;
      jobs = 40;
      for (int i = 0; i < jobs; i++) begin
         if ($urandom_range(1) == 0)
            q0.push_back(mk(4'($urandom_range(3)), 3'($urandom_range(7)), 1'($urandom_range(1)),
                            $urandom, $urandom, $urandom, 1'b0, 32'h0));
         else
            q1.push_back(mk(4'($urandom_range(3)), 3'($urandom_range(7)), 1'($urandom_range(1)),
                            $urandom, $urandom, $urandom, 1'b0, 32'h0));
      end
      run_until_idle(6000);
      check("random_jobs_done", 128'(m_done), 128'(jobs));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
